// File: rtl/controller_sequencer.sv
// Next-state sequencer for the SAM CPU controller: 4-bit microcode ROM address,
// opcode dispatch, memory wait states, halt at instruction boundaries, timeout, retire count.
module controller_sequencer #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16,
  parameter int WAIT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       opcode,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic [3:0]       state,
  output logic             mem_wait,
  output logic             instr_done,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_RES = 4'd0,  S_IF0 = 4'd1,  S_IF1 = 4'd2,  S_IF2 = 4'd3,
    S_IF3 = 4'd4,  S_OD  = 4'd5,  S_LD0 = 4'd6,  S_LD1 = 4'd7,
    S_LD2 = 4'd8,  S_ST0 = 4'd9,  S_ST1 = 4'd10, S_AD0 = 4'd11,
    S_AD1 = 4'd12, S_AD2 = 4'd13, S_BR0 = 4'd14, S_BR1 = 4'd15
  } state_t;

  localparam logic [WAIT_W-1:0] L_MAX_WAIT = WAIT_W'(MAX_WAIT);

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_stall;
  logic                r_bus_err;
  logic                r_instr_done;
  logic [CNT_W-1:0]    r_retired;
  logic                w_is_wait;
  logic                w_is_term;
  logic                w_stall;
  logic                w_timeout;
  logic                w_retire;

  always_comb begin
    w_next    = r_state;
    w_is_wait = (r_state == S_IF1) || (r_state == S_LD1) ||
                (r_state == S_ST1) || (r_state == S_AD1);
    w_is_term = (r_state == S_LD2) || (r_state == S_ST1) ||
                (r_state == S_AD2) || (r_state == S_BR1);
    w_stall   = w_is_wait && !mem_ready;
    // A wait state may stall MAX_WAIT cycles; one more stall aborts to RES.
    w_timeout = w_stall && (MAX_WAIT != 0) && (r_stall == L_MAX_WAIT);
    w_retire  = 1'b0;

    case (r_state)
      S_RES: if (!halt_req && !r_bus_err) w_next = S_IF0;
      S_IF0: w_next = S_IF1;
      S_IF1: if (mem_ready) w_next = S_IF2;
      S_IF2: w_next = S_IF3;
      S_IF3: w_next = S_OD;
      S_OD: begin
        case (opcode)
          2'b00:   w_next = S_LD0;
          2'b01:   w_next = S_ST0;
          2'b10:   w_next = S_AD0;
          default: w_next = S_BR0;
        endcase
      end
      S_LD0: w_next = S_LD1;
      S_LD1: if (mem_ready) w_next = S_LD2;
      S_ST0: w_next = S_ST1;
      S_AD0: w_next = S_AD1;
      S_AD1: if (mem_ready) w_next = S_AD2;
      S_BR0: w_next = S_BR1;
      default: w_next = r_state;
    endcase

    // Terminal states: ST1 only leaves once its memory access completes.
    if (w_is_term && !w_stall) begin
      w_next   = halt_req ? S_RES : S_IF0;
      w_retire = 1'b1;
    end

    if (w_timeout) w_next = S_RES;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RES;
      r_stall      <= '0;
      r_bus_err    <= 1'b0;
      r_instr_done <= 1'b0;
      r_retired    <= '0;
    end else begin
      r_state      <= w_next;
      r_stall      <= (w_stall && !w_timeout) ? r_stall + 1'b1 : '0;
      r_bus_err    <= r_bus_err | w_timeout;
      r_instr_done <= w_retire;
      r_retired    <= r_retired + CNT_W'(w_retire);
    end
  end

  assign state      = r_state;
  assign mem_wait   = w_stall;
  assign instr_done = r_instr_done;
  assign halted     = (r_state == S_RES);
  assign bus_err    = r_bus_err;
  assign retired    = r_retired;

endmodule
